// File: rtl/raizing_video_pkg.sv
// Shared definitions for the Raizing video interrupt block: timing defaults,
// the interrupt FSM state type and the bit layout of the vcount word.
package raizing_video_pkg;

  localparam int HS_START_DEF = 325;
  localparam int V_TOTAL_DEF  = 263;
  localparam int HOLDOFF_DEF  = 16;

  // vcount word: {~lvbl, ~lhbl, 5'b0, line[8:0]}
  localparam int VC_LINE_W  = 9;
  localparam int VC_HBL_BIT = 14;
  localparam int VC_VBL_BIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } vint_state_e;

endpackage

// File: rtl/raizing_vint_ctrl_if.sv
// CPU-side bus of the interrupt controller.
// Handshake: vint_n is a level request held low in ASSERT until irq_ack, a
// one-cycle strobe, is seen; irq_ack outside ASSERT is ignored. vcnt_rd is a
// one-cycle strobe; the cycle after it vcnt_vld pulses for exactly one cycle
// together with the fresh vcnt_q, which then holds until the next strobe.
interface raizing_vint_ctrl_if;
  logic        irq_ack;
  logic        vcnt_rd;
  logic        vint_n;
  logic [1:0]  irq_src;
  logic [15:0] vcnt_q;
  logic        vcnt_vld;

  modport master (
    output irq_ack, vcnt_rd,
    input  vint_n, irq_src, vcnt_q, vcnt_vld
  );

  modport slave (
    input  irq_ack, vcnt_rd,
    output vint_n, irq_src, vcnt_q, vcnt_vld
  );
endinterface

// File: rtl/raizing_vcnt_latch.sv
// GCU vcount read port: computes the line number the GCU reports (it advances
// at HS_START, wrapping at the frame end) and latches it with the blank flags
// on every read strobe.
module raizing_vcnt_latch
  import raizing_video_pkg::*;
#(
  parameter int HS_START = HS_START_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF
) (
  input  logic        clk96,
  input  logic        reset96_n,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  input  logic        lvbl,
  input  logic        lhbl,
  input  logic        vcnt_rd,
  output logic [15:0] vcnt_q,
  output logic        vcnt_vld
);

  logic [8:0]  vc;
  logic [15:0] word;

  // Line number as seen by the GCU plus the assembled status word.
  always_comb begin
    vc = vpos;
    if (hpos >= 9'(HS_START)) begin
      vc = (vpos == 9'(V_TOTAL - 1)) ? 9'd0 : vpos + 9'd1;
    end
    word                  = '0;
    word[VC_VBL_BIT]      = ~lvbl;
    word[VC_HBL_BIT]      = ~lhbl;
    word[VC_LINE_W-1:0]   = vc;
  end

  // Capture on every strobe; the valid pulse simply follows the strobe.
  always_ff @(posedge clk96 or negedge reset96_n) begin
    if (!reset96_n) begin
      vcnt_q   <= '0;
      vcnt_vld <= 1'b0;
    end else begin
      vcnt_vld <= vcnt_rd;
      if (vcnt_rd) vcnt_q <= word;
    end
  end

endmodule

// File: rtl/raizing_vint_ctrl.sv
// Vertical interrupt controller: merges vblank and raster events into pending
// flags, raises vint_n until acknowledged, then enforces a holdoff period
// before the next assertion. Also hosts the GCU vcount read port.
module raizing_vint_ctrl
  import raizing_video_pkg::*;
#(
  parameter int HS_START = HS_START_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int HOLDOFF  = HOLDOFF_DEF
) (
  input  logic                 clk96,
  input  logic                 reset96_n,
  input  logic                 pxl_cen,
  input  logic [8:0]           hpos,
  input  logic [8:0]           vpos,
  input  logic                 lvbl,
  input  logic                 lhbl,
  input  logic                 vbl_en,
  input  logic                 ras_en,
  input  logic [8:0]           ras_line,
  raizing_vint_ctrl_if.slave   cpu,
  output vint_state_e          state_dbg
);

  localparam int CW = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);

  vint_state_e   state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [1:0]    pend_q, pend_n, pend_eff, set_ev, src_q, src_n;
  logic          lvbl_q, armed_q, load;
  logic [15:0]   vcnt_q_w;
  logic          vcnt_vld_w;

  // lvbl edge history, advanced only on pixel enables. armed_q suppresses the
  // edge test on the first enable after reset so a frame already in vblank
  // does not look like a fresh 1->0 transition.
  always_ff @(posedge clk96 or negedge reset96_n) begin
    if (!reset96_n) begin
      lvbl_q  <= 1'b1;
      armed_q <= 1'b0;
    end else if (pxl_cen) begin
      lvbl_q  <= lvbl;
      armed_q <= 1'b1;
    end
  end

  // Event detection and pending update; disabling a source drops its flag
  // immediately, and a new event wins over the clear that a load performs.
  always_comb begin
    pend_eff  = pend_q & {ras_en, vbl_en};
    set_ev[0] = pxl_cen & armed_q & lvbl_q & ~lvbl & vbl_en;
    set_ev[1] = pxl_cen & ras_en & (vpos == ras_line) & (hpos == 9'(HS_START));
    pend_n    = (pend_eff & ~(load ? pend_eff : 2'b00)) | set_ev;
  end

  // Next-state logic for IDLE -> ASSERT -> HOLD -> IDLE.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    src_n   = src_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pend_eff) begin
          state_n = ST_ASSERT;
          src_n   = pend_eff;
          load    = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (cpu.irq_ack) begin
          state_n = ST_HOLD;
          cnt_n   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_n = ST_IDLE;
        else             cnt_n   = cnt_q - 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, holdoff counter, cause register and pending flags.
  always_ff @(posedge clk96 or negedge reset96_n) begin
    if (!reset96_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= 2'b00;
      pend_q  <= 2'b00;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      src_q   <= src_n;
      pend_q  <= pend_n;
    end
  end

  raizing_vcnt_latch #(
    .HS_START (HS_START),
    .V_TOTAL  (V_TOTAL)
  ) u_vcnt (
    .clk96     (clk96),
    .reset96_n (reset96_n),
    .hpos      (hpos),
    .vpos      (vpos),
    .lvbl      (lvbl),
    .lhbl      (lhbl),
    .vcnt_rd   (cpu.vcnt_rd),
    .vcnt_q    (vcnt_q_w),
    .vcnt_vld  (vcnt_vld_w)
  );

  // vint_n decodes straight from the state so reset releases it at once.
  assign cpu.vint_n   = (state_q != ST_ASSERT);
  assign cpu.irq_src  = src_q;
  assign cpu.vcnt_q   = vcnt_q_w;
  assign cpu.vcnt_vld = vcnt_vld_w;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_raizing_vint_ctrl.sv
// Directed bench for raizing_vint_ctrl: vblank/raster interrupts, holdoff,
// merging, enable clearing, vcount reads and asynchronous reset.
module tb_raizing_vint_ctrl;
  import raizing_video_pkg::*;

  logic        clk96 = 1'b0;
  logic        reset96_n;
  logic        pxl_cen;
  logic [8:0]  hpos, vpos, ras_line;
  logic        lvbl, lhbl, vbl_en, ras_en;
  vint_state_e state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  raizing_vint_ctrl_if cpu_if ();

  raizing_vint_ctrl #(
    .HS_START (325),
    .V_TOTAL  (263),
    .HOLDOFF  (16)
  ) dut (
    .clk96     (clk96),
    .reset96_n (reset96_n),
    .pxl_cen   (pxl_cen),
    .hpos      (hpos),
    .vpos      (vpos),
    .lvbl      (lvbl),
    .lhbl      (lhbl),
    .vbl_en    (vbl_en),
    .ras_en    (ras_en),
    .ras_line  (ras_line),
    .cpu       (cpu_if),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk96 = ~clk96;

  task automatic tick();
    @(posedge clk96);
    #1;
  endtask

  // Pulse acknowledge, then wait (bounded) for the FSM to come back to IDLE.
  task automatic finish_irq(input string name);
    cpu_if.irq_ack = 1'b1;
    tick();
    cpu_if.irq_ack = 1'b0;
    for (int i = 0; i < 40 && state_dbg != ST_IDLE; i++) tick();
    n_cmp++;
    if (state_dbg !== ST_IDLE) begin
      n_bad++;
      $display("FAIL %s_idle: observed state %0d, required %0d", name, state_dbg, ST_IDLE);
    end
  endtask

  task automatic test_reset();
    reset96_n = 1'b0; pxl_cen = 1'b1; hpos = '0; vpos = '0; ras_line = '0;
    lvbl = 1'b1; lhbl = 1'b1; vbl_en = 1'b0; ras_en = 1'b0;
    cpu_if.irq_ack = 1'b0; cpu_if.vcnt_rd = 1'b0;
    #1;
    n_cmp++;
    if (cpu_if.vint_n !== 1'b1) begin n_bad++; $display("FAIL rst_vint_n: observed %0h, required 1", cpu_if.vint_n); end
    n_cmp++;
    if (cpu_if.irq_src !== 2'b00) begin n_bad++; $display("FAIL rst_irq_src: observed %0h, required 0", cpu_if.irq_src); end
    n_cmp++;
    if (cpu_if.vcnt_q !== 16'h0000 || cpu_if.vcnt_vld !== 1'b0) begin
      n_bad++; $display("FAIL rst_vcnt: observed %0h/%0h, required 0/0", cpu_if.vcnt_q, cpu_if.vcnt_vld);
    end
    n_cmp++;
    if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL rst_state: observed %0d, required 0", state_dbg); end
    tick(); tick();
    reset96_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_vblank();
    int hold_cycles;
    vbl_en = 1'b1; lvbl = 1'b1; pxl_cen = 1'b1;
    tick();
    lvbl = 1'b0;
    tick();
    n_cmp++;
    if (cpu_if.vint_n !== 1'b1) begin n_bad++; $display("FAIL vbl_early: observed %0h, required 1", cpu_if.vint_n); end
    tick();
    n_cmp++;
    if (cpu_if.vint_n !== 1'b0) begin n_bad++; $display("FAIL vbl_assert: observed %0h, required 0", cpu_if.vint_n); end
    n_cmp++;
    if (cpu_if.irq_src !== 2'b01) begin n_bad++; $display("FAIL vbl_src: observed %0h, required 1", cpu_if.irq_src); end
    tick(); tick();
    n_cmp++;
    if (cpu_if.vint_n !== 1'b0) begin n_bad++; $display("FAIL vbl_held: observed %0h, required 0", cpu_if.vint_n); end
    cpu_if.irq_ack = 1'b1;
    tick();
    cpu_if.irq_ack = 1'b0;
    hold_cycles = 0;
    for (int i = 0; i < 40 && state_dbg == ST_HOLD; i++) begin
      hold_cycles++;
      n_cmp++;
      if (cpu_if.vint_n !== 1'b1) begin n_bad++; $display("FAIL hold_vint_n: observed %0h, required 1", cpu_if.vint_n); end
      tick();
    end
    n_cmp++;
    if (hold_cycles !== 16) begin n_bad++; $display("FAIL hold_len: observed %0d, required 16", hold_cycles); end
    n_cmp++;
    if (state_dbg !== ST_IDLE || cpu_if.vint_n !== 1'b1) begin
      n_bad++; $display("FAIL hold_end: observed state %0d vint_n %0h, required 0/1", state_dbg, cpu_if.vint_n);
    end
    // acknowledge in IDLE is ignored
    cpu_if.irq_ack = 1'b1;
    tick();
    cpu_if.irq_ack = 1'b0;
    tick();
    n_cmp++;
    if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL idle_ack: observed %0d, required 0", state_dbg); end
    vbl_en = 1'b0; lvbl = 1'b1;
    tick();
  endtask

  task automatic test_raster();
    ras_en = 1'b1; ras_line = 9'd100; vpos = 9'd100; hpos = 9'd325; pxl_cen = 1'b0;
    tick(); tick();
    hpos = 9'd0; pxl_cen = 1'b1;
    tick();
    n_cmp++;
    if (cpu_if.vint_n !== 1'b1 || state_dbg !== ST_IDLE) begin
      n_bad++; $display("FAIL ras_no_cen: observed vint_n %0h state %0d, required 1/0", cpu_if.vint_n, state_dbg);
    end
    hpos = 9'd325;
    tick();
    hpos = 9'd0;
    tick();
    n_cmp++;
    if (cpu_if.vint_n !== 1'b0) begin n_bad++; $display("FAIL ras_assert: observed %0h, required 0", cpu_if.vint_n); end
    n_cmp++;
    if (cpu_if.irq_src !== 2'b10) begin n_bad++; $display("FAIL ras_src: observed %0h, required 2", cpu_if.irq_src); end
    finish_irq("ras");
    ras_en = 1'b0;
  endtask

  task automatic test_both_and_hold();
    vbl_en = 1'b1; ras_en = 1'b1; lvbl = 1'b1;
    tick();
    lvbl = 1'b0; vpos = 9'd100; ras_line = 9'd100; hpos = 9'd325;
    tick();
    hpos = 9'd0;
    tick();
    n_cmp++;
    if (cpu_if.vint_n !== 1'b0 || cpu_if.irq_src !== 2'b11) begin
      n_bad++; $display("FAIL both_src: observed vint_n %0h src %0h, required 0/3", cpu_if.vint_n, cpu_if.irq_src);
    end
    cpu_if.irq_ack = 1'b1;
    tick();
    cpu_if.irq_ack = 1'b0;
    lvbl = 1'b1;
    tick();
    lvbl = 1'b0;
    tick();
    n_cmp++;
    if (state_dbg !== ST_HOLD || cpu_if.vint_n !== 1'b1) begin
      n_bad++; $display("FAIL hold_event: observed state %0d vint_n %0h, required 2/1", state_dbg, cpu_if.vint_n);
    end
    for (int i = 0; i < 40 && state_dbg != ST_IDLE; i++) tick();
    tick();
    n_cmp++;
    if (cpu_if.vint_n !== 1'b0 || cpu_if.irq_src !== 2'b01) begin
      n_bad++; $display("FAIL reassert: observed vint_n %0h src %0h, required 0/1", cpu_if.vint_n, cpu_if.irq_src);
    end
    // two vblank edges while asserted merge into one pending event
    lvbl = 1'b1; tick(); lvbl = 1'b0; tick();
    lvbl = 1'b1; tick(); lvbl = 1'b0; tick();
    finish_irq("merge_a");
    tick();
    n_cmp++;
    if (cpu_if.vint_n !== 1'b0 || cpu_if.irq_src !== 2'b01) begin
      n_bad++; $display("FAIL merge_one: observed vint_n %0h src %0h, required 0/1", cpu_if.vint_n, cpu_if.irq_src);
    end
    finish_irq("merge_b");
    tick(); tick(); tick();
    n_cmp++;
    if (cpu_if.vint_n !== 1'b1) begin n_bad++; $display("FAIL merge_extra: observed %0h, required 1", cpu_if.vint_n); end
    vbl_en = 1'b0; ras_en = 1'b0; lvbl = 1'b1;
    tick();
  endtask

  task automatic test_ras_clear();
    vbl_en = 1'b1; ras_en = 1'b1; lvbl = 1'b1; ras_line = 9'd100; vpos = 9'd100; hpos = 9'd0;
    tick();
    lvbl = 1'b0;
    tick(); tick();
    n_cmp++;
    if (cpu_if.vint_n !== 1'b0 || cpu_if.irq_src !== 2'b01) begin
      n_bad++; $display("FAIL rclr_first: observed vint_n %0h src %0h, required 0/1", cpu_if.vint_n, cpu_if.irq_src);
    end
    cpu_if.irq_ack = 1'b1;
    tick();
    cpu_if.irq_ack = 1'b0;
    hpos = 9'd325;
    tick();
    hpos = 9'd0; ras_en = 1'b0;
    tick();
    for (int i = 0; i < 40 && state_dbg != ST_IDLE; i++) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (cpu_if.vint_n !== 1'b1) begin n_bad++; $display("FAIL rclr_none: observed %0h, required 1", cpu_if.vint_n); end
    end
    vbl_en = 1'b0; lvbl = 1'b1;
    tick();
  endtask

  task automatic test_vcnt();
    vbl_en = 1'b0; ras_en = 1'b0;
    vpos = 9'd262; hpos = 9'd330; lvbl = 1'b0; lhbl = 1'b0; cpu_if.vcnt_rd = 1'b1;
    tick();
    cpu_if.vcnt_rd = 1'b0;
    n_cmp++;
    if (cpu_if.vcnt_q !== 16'hC000 || cpu_if.vcnt_vld !== 1'b1) begin
      n_bad++; $display("FAIL vcnt_wrap: observed %0h vld %0h, required c000/1", cpu_if.vcnt_q, cpu_if.vcnt_vld);
    end
    vpos = 9'd7; hpos = 9'd3; lvbl = 1'b1; lhbl = 1'b1;
    tick();
    n_cmp++;
    if (cpu_if.vcnt_q !== 16'hC000 || cpu_if.vcnt_vld !== 1'b0) begin
      n_bad++; $display("FAIL vcnt_hold: observed %0h vld %0h, required c000/0", cpu_if.vcnt_q, cpu_if.vcnt_vld);
    end
    vpos = 9'd50; hpos = 9'd10; cpu_if.vcnt_rd = 1'b1;
    tick();
    n_cmp++;
    if (cpu_if.vcnt_q !== 16'h0032 || cpu_if.vcnt_vld !== 1'b1) begin
      n_bad++; $display("FAIL vcnt_50: observed %0h vld %0h, required 0032/1", cpu_if.vcnt_q, cpu_if.vcnt_vld);
    end
    vpos = 9'd100; hpos = 9'd325;
    tick();
    n_cmp++;
    if (cpu_if.vcnt_q !== 16'h0065 || cpu_if.vcnt_vld !== 1'b1) begin
      n_bad++; $display("FAIL vcnt_b2b: observed %0h vld %0h, required 0065/1", cpu_if.vcnt_q, cpu_if.vcnt_vld);
    end
    vpos = 9'd262; hpos = 9'd324; lhbl = 1'b0;
    tick();
    cpu_if.vcnt_rd = 1'b0;
    n_cmp++;
    if (cpu_if.vcnt_q !== 16'h4106 || cpu_if.vcnt_vld !== 1'b1) begin
      n_bad++; $display("FAIL vcnt_324: observed %0h vld %0h, required 4106/1", cpu_if.vcnt_q, cpu_if.vcnt_vld);
    end
    tick();
    n_cmp++;
    if (cpu_if.vcnt_vld !== 1'b0) begin n_bad++; $display("FAIL vcnt_vld_end: observed %0h, required 0", cpu_if.vcnt_vld); end
    vpos = 9'd0; hpos = 9'd0; lhbl = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    vbl_en = 1'b1; lvbl = 1'b1;
    tick();
    lvbl = 1'b0;
    tick(); tick();
    n_cmp++;
    if (cpu_if.vint_n !== 1'b0) begin n_bad++; $display("FAIL rmid_assert: observed %0h, required 0", cpu_if.vint_n); end
    reset96_n = 1'b0;
    #1;
    n_cmp++;
    if (cpu_if.vint_n !== 1'b1 || state_dbg !== ST_IDLE) begin
      n_bad++; $display("FAIL rmid_async: observed vint_n %0h state %0d, required 1/0", cpu_if.vint_n, state_dbg);
    end
    tick(); tick();
    reset96_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (cpu_if.vint_n !== 1'b1) begin n_bad++; $display("FAIL rmid_no_edge: observed %0h, required 1", cpu_if.vint_n); end
    end
    lvbl = 1'b1;
    tick();
    lvbl = 1'b0;
    tick(); tick();
    n_cmp++;
    if (cpu_if.vint_n !== 1'b0 || cpu_if.irq_src !== 2'b01) begin
      n_bad++; $display("FAIL rmid_next_edge: observed vint_n %0h src %0h, required 0/1", cpu_if.vint_n, cpu_if.irq_src);
    end
    finish_irq("rmid");
    vbl_en = 1'b0; lvbl = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_vblank();
    test_raster();
    test_both_and_hold();
    test_ras_clear();
    test_vcnt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/raizing_vint_ctrl.md
RAIZING_VINT_CTRL -- requirements
Module: raizing_vint_ctrl

Interface
REQ-001 Parameters (name, default, meaning): HS_START, 325, hpos at which the GCU line counter advances and the raster compare fires; V_TOTAL, 263, lines per frame (vpos 0..262); HOLDOFF, 16, minimum clk96 cycles vint_n stays high after an acknowledge.
REQ-002 Ports (name direction width meaning): clk96 in 1 system clock; reset96_n in 1 asynchronous active-low reset; pxl_cen in 1 pixel clock enable.
REQ-003 hpos in 9 and vpos in 9: raster position from the video timer; lvbl in 1, low during vertical blank; lhbl in 1, low during horizontal blank.
REQ-004 Configuration inputs: vbl_en in 1 enables the vblank source; ras_en in 1 enables the raster source; ras_line in 9 selects the raster compare line.
REQ-005 irq_ack in 1: one-cycle CPU acknowledge strobe; vcnt_rd in 1: one-cycle GCU vcount read strobe.
REQ-006 Outputs: vint_n out 1, active-low CPU interrupt; irq_src out 2, {raster, vblank} cause of the current assertion; vcnt_q out 16, latched vcount word; vcnt_vld out 1, one-cycle valid pulse.

Function
REQ-007 Vblank event: a 1->0 transition of lvbl sampled on a pxl_cen cycle, qualified by vbl_en, sets vbl_pend.
REQ-008 Raster event: a pxl_cen cycle with vpos==ras_line and hpos==HS_START, qualified by ras_en, sets ras_pend.
REQ-009 Events occur only on pxl_cen cycles; a cycle without pxl_cen neither sets pending flags nor updates the lvbl edge register.
REQ-010 FSM states: IDLE, ASSERT, HOLD.
REQ-011 IDLE: when vbl_pend or ras_pend is set, go to ASSERT on the next cycle, load irq_src with all pending bits, and clear those pending bits.
REQ-012 ASSERT: vint_n=0; irq_ack moves the FSM to HOLD and loads the holdoff counter with HOLDOFF-1.
REQ-013 HOLD: vint_n=1; the counter decrements each clk96 cycle; at zero go to IDLE; irq_ack in HOLD or IDLE is ignored.
REQ-014 An event that arrives while in ASSERT or HOLD sets its pending flag and is serviced from IDLE after HOLD completes; a repeat of a source whose flag is already set is merged and not counted.
REQ-015 An event coinciding with the IDLE->ASSERT load stays pending: set takes priority over clear for that source.
REQ-016 Clearing vbl_en or ras_en clears that source's pending flag in the same cycle; an assertion already in progress is not withdrawn.
REQ-017 vcount value: vc = vpos+1 when hpos>=HS_START, else vpos; vpos==V_TOTAL-1 with hpos>=HS_START yields 0 (wrap).
REQ-018 On vcnt_rd, the next cycle vcnt_q = {~lvbl, ~lhbl, 5'b0, vc[8:0]} sampled at the strobe cycle, and vcnt_vld=1 for exactly one cycle.
REQ-019 vcnt_q holds its value between reads; back-to-back vcnt_rd strobes each produce a fresh sample and a vcnt_vld pulse.

Reset
REQ-020 While reset96_n is low: FSM=IDLE, vint_n=1, irq_src=0, pending flags=0, holdoff counter=0, vcnt_q=0, vcnt_vld=0, lvbl edge register=1.
REQ-021 Reset asserted mid-ASSERT or mid-HOLD releases vint_n immediately (asynchronously); no event is remembered across reset.
REQ-022 Release of reset96_n while lvbl is already low does not create a vblank event.

Structure
REQ-023 Shared package raizing_video_pkg holds the FSM state enum, the default HS_START/V_TOTAL constants, and the vcount bit-position constants.
REQ-024 One sub-module, raizing_vcnt_latch, implements REQ-017..REQ-019; the FSM, pending flags and holdoff counter remain in the top module.

Verification
REQ-025 vbl_en=1, lvbl falls on a pxl_cen cycle -> vint_n low two cycles later, irq_src=01; irq_ack -> vint_n high for exactly 16 cycles, then FSM in IDLE.
REQ-026 ras_en=1, ras_line=100, vpos=100, hpos=325 on a pxl_cen cycle -> vint_n=0, irq_src=10; same position without pxl_cen -> no event.
REQ-027 Vblank and raster events in the same cycle -> a single assertion with irq_src=11; a second vblank during HOLD -> re-assert after HOLD with irq_src=01.
REQ-028 vcnt_rd at vpos=262, hpos=330, lvbl=0, lhbl=0 -> vcnt_q=0xC000, vcnt_vld for one cycle; vcnt_rd at vpos=50, hpos=10, lvbl=1, lhbl=1 -> vcnt_q=0x0032.
REQ-029 reset96_n pulsed low during ASSERT -> vint_n=1 asynchronously; after release with lvbl held low -> no assertion until the next 1->0 edge of lvbl.
REQ-030 ras_en cleared while ras_pend is set during HOLD -> no raster assertion after HOLD.
